tex_cache_2way: RTL
===================

TEX_CACHE_2WAY -- requirements
Module: tex_cache_2way

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of independent lookup ports (1..4).
REQ-002 SHALL have parameter INDEX_BITS, default 8, set-index width; sets = 2^INDEX_BITS; tag width TAG_BITS = 17-INDEX_BITS.
REQ-003 SHALL have port i_clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port i_clearCache  in  1  invalidate all lines.
REQ-006 SHALL have port i_textureFormatTrueColor  in  1  selects the swizzle mode: 1 = 16bpp, 0 = 4/8bpp.
REQ-007 SHALL have port i_write  in  1  snooped VRAM write strobe.
REQ-008 SHALL have port i_adressIn  in  17  write address in 8-byte blocks.
REQ-009 SHALL have port i_dataIn  in  64  write data, atomic 64-bit block.
REQ-010 SHALL have port i_requLookup  in  NUM_PORTS  per-port lookup request.
REQ-011 SHALL have port i_adressLook  in  NUM_PORTS*19  per-port halfword address; port p occupies bits [19p+18:19p].
REQ-012 SHALL have port o_dataOut  out  NUM_PORTS*16  per-port halfword result.
REQ-013 SHALL have port o_isHit  out  NUM_PORTS  per-port hit.
REQ-014 SHALL have port o_isMiss  out  NUM_PORTS  per-port miss, sticky.

Function
REQ-015 SHALL form the block address from a 17-bit address a as follows.
- True-colour mode: {a[16:13],a[7:3],a[12:8],a[2:0]}.
- 4/8bpp mode: {a[16:14],a[7:2],a[13:8],a[1:0]}.
- Lookups use a = i_adressLook[18:2].
- Set = swizzled[INDEX_BITS-1:0]; tag = swizzled[16:INDEX_BITS].
REQ-016 SHALL be 2-way set-associative; each set holds two ways, each way holding a valid bit, a tag and 64 data bits, plus one LRU bit per set.
REQ-017 SHALL have a lookup latency of exactly 1 cycle: a request in cycle N produces hit, miss and data in cycle N+1. Halfword select is the registered i_adressLook[1:0], where 0 selects bits [15:0] and 3 selects bits [63:48].
REQ-018 SHALL define hit(p) = registered request AND (way0 valid with tag match OR way1 valid with tag match). Data comes from the matching way; if both ways match, way 0 wins.
REQ-019 SHALL drive o_isMiss[p] = (registered request AND NOT hit) OR (sticky[p] AND NOT hit).
- sticky[p] sets on o_isMiss[p].
- sticky[p] clears on o_isHit[p] or i_clearCache.
REQ-020 SHALL handle a write as follows.
- If a valid way in the set matches the tag: overwrite that way.
- Else if a way is invalid: fill the lowest-numbered invalid way.
- Else: replace the way pointed to by LRU.
- The written way becomes valid, and LRU is set to point at the other way.
REQ-021 SHALL update LRU on a lookup hit so that it points at the way not hit. If several ports hit the same set in one cycle, the lowest port index determines the update. A write to that set in the same cycle overrides all lookup LRU updates.
REQ-022 SHALL be write-first: a lookup in the same cycle as a write to the same set returns the post-write content (hit with the new data if the tag matches). This requires a per-way bypass of the RAM output.
REQ-023 SHALL treat i_clearCache as follows.
- All valid bits clear and all LRU bits reset to 0 in one cycle.
- Clear beats a simultaneous write: the line is not validated.
- A lookup issued in the clear cycle returns miss in N+1.
REQ-024 SHALL leave o_dataOut[p] undefined unless o_isHit[p] is 1.

Reset
REQ-025 SHALL, on i_rst, clear all valid bits, LRU bits, sticky bits and registered requests, so that o_isHit = 0 and o_isMiss = 0 in the cycle after reset.
REQ-026 SHALL give reset priority over i_clearCache and i_write. A request asserted during reset produces no hit or miss.
REQ-027 SHALL NOT require the tag/data RAM contents to be reset.

Structure
REQ-028 SHALL place the address-width constants (17, 19), the swizzle function and a way-entry typedef (tag + data) in package tex_cache_pkg.
REQ-029 SHALL instantiate sub-module tex_cache_way_ram: 1 write port, NUM_PORTS registered read ports, depth 2^INDEX_BITS, write-first bypass. There is one instance per way.
REQ-030 SHALL hold valid and LRU bits in flops, not in RAM.

Verification
REQ-031 SHALL cover a cold miss and fill.
- Lookup port0 at 0x00000 -> o_isMiss[0]=1 in N+1.
- Write adressIn 0x00000, data 0x4444_3333_2222_1111.
- Lookup 0x00002 -> hit, o_dataOut[0]=0x3333; sticky miss cleared.
REQ-032 SHALL cover conflict and LRU with INDEX_BITS=8 in true-colour mode.
- Write three blocks with the same set and distinct tags: A, B, then lookup-hit A, then write C.
- Then lookups of A and C hit, and B misses (B was LRU).
REQ-033 SHALL cover write-bypass: write 0x00010 and look up the same address in the same cycle -> hit with the new data in N+1.
REQ-034 SHALL cover clear/write collision: i_clearCache and i_write in the same cycle -> subsequent lookup of that address misses.
REQ-035 SHALL cover multi-port operation with NUM_PORTS=4.
- All ports look up in one cycle, two hitting and two missing -> per-port hit/miss is independent.
- Sticky miss on a missing port persists over idle cycles until that block is written and looked up.
REQ-036 SHALL cover mid-operation reset: i_rst asserted while lookups are pending -> next cycle all hit/miss = 0, and a previously written block now misses.

Source files
------------

// File: rtl/tex_cache_pkg.sv
// Shared constants, way-entry layout and address swizzle for the texture cache.
// Purely combinational helpers; no latency, no flow control.
package tex_cache_pkg;

    localparam int ADDR_BITS = 17;
    localparam int LOOK_BITS = 19;

    // Tag is kept at full address width; bits above the real tag are always zero.
    typedef struct packed {
        logic [ADDR_BITS-1:0] tag;
        logic [63:0]          data;
    } wayEntry_t;

    function automatic logic [ADDR_BITS-1:0] swizzle(input logic [ADDR_BITS-1:0] a,
                                                     input logic trueColor);
        return trueColor ? {a[16:13], a[7:3], a[12:8], a[2:0]}
                         : {a[16:14], a[7:2], a[13:8], a[1:0]};
    endfunction

endpackage

// File: rtl/tex_cache_way_ram.sv
// One cache way: single write port, NUM_PORTS registered read ports with write-first bypass.
// Read latency 1 cycle; no backpressure. The write-address probe is read combinationally.
module tex_cache_way_ram
    import tex_cache_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int INDEX_BITS = 8
)(
    input  logic                            i_clk,
    input  logic                            i_we,
    input  logic [INDEX_BITS-1:0]           i_wrAddr,
    input  wayEntry_t                       i_wrData,
    output wayEntry_t                       o_wrProbe,
    input  logic [NUM_PORTS*INDEX_BITS-1:0] i_rdAddr,
    output wayEntry_t [NUM_PORTS-1:0]       o_rdData
);

    wayEntry_t mem [2**INDEX_BITS];

    // The write path needs the stored tag of the target set in the same cycle.
    assign o_wrProbe = mem[i_wrAddr];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_wrAddr] <= i_wrData;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (i_we && i_wrAddr == i_rdAddr[p*INDEX_BITS +: INDEX_BITS])
                o_rdData[p] <= i_wrData;
            else
                o_rdData[p] <= mem[i_rdAddr[p*INDEX_BITS +: INDEX_BITS]];
        end
    end

endmodule

// File: rtl/tex_cache_2way.sv
// Multi-port 2-way set-associative texture cache filled by snooped VRAM writes.
// Lookup latency 1 cycle; no backpressure, a missing port holds o_isMiss until it hits.
module tex_cache_2way
    import tex_cache_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int INDEX_BITS = 8
)(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clearCache,
    input  logic                           i_textureFormatTrueColor,
    input  logic                           i_write,
    input  logic [ADDR_BITS-1:0]           i_adressIn,
    input  logic [63:0]                    i_dataIn,
    input  logic [NUM_PORTS-1:0]           i_requLookup,
    input  logic [NUM_PORTS*LOOK_BITS-1:0] i_adressLook,
    output logic [NUM_PORTS*16-1:0]        o_dataOut,
    output logic [NUM_PORTS-1:0]           o_isHit,
    output logic [NUM_PORTS-1:0]           o_isMiss
);

    localparam int SETS = 2**INDEX_BITS;

    logic [SETS-1:0] valid0, valid1, lru;

    logic [ADDR_BITS-1:0]  wrSwz, wrTag;
    logic [INDEX_BITS-1:0] wrSet;
    logic                  wrEn, wrWay;
    logic [1:0]            wrMatch;
    wayEntry_t             wrEntry, probe0, probe1;

    logic [NUM_PORTS*INDEX_BITS-1:0] lkSet;
    logic [ADDR_BITS-1:0]            lkTag  [NUM_PORTS];
    logic [INDEX_BITS-1:0]           setR   [NUM_PORTS];
    logic [ADDR_BITS-1:0]            tagR   [NUM_PORTS];
    logic [1:0]                      selR   [NUM_PORTS];
    logic [NUM_PORTS-1:0]            reqR, sticky, hitWay0;
    wayEntry_t [NUM_PORTS-1:0]       rd0, rd1;

    assign wrSwz   = swizzle(i_adressIn, i_textureFormatTrueColor);
    assign wrSet   = wrSwz[INDEX_BITS-1:0];
    assign wrTag   = wrSwz >> INDEX_BITS;
    assign wrEn    = i_write && !i_rst;
    assign wrEntry = '{tag: wrTag, data: i_dataIn};

    // Victim choice: existing match, then lowest invalid way, then LRU.
    always_comb begin
        wrMatch[0] = valid0[wrSet] && probe0.tag == wrTag;
        wrMatch[1] = valid1[wrSet] && probe1.tag == wrTag;
        if (wrMatch[0])           wrWay = 1'b0;
        else if (wrMatch[1])      wrWay = 1'b1;
        else if (!valid0[wrSet])  wrWay = 1'b0;
        else if (!valid1[wrSet])  wrWay = 1'b1;
        else                      wrWay = lru[wrSet];
    end

    tex_cache_way_ram #(.NUM_PORTS(NUM_PORTS), .INDEX_BITS(INDEX_BITS)) u_way0 (
        .i_clk(i_clk), .i_we(wrEn && !wrWay), .i_wrAddr(wrSet), .i_wrData(wrEntry),
        .o_wrProbe(probe0), .i_rdAddr(lkSet), .o_rdData(rd0)
    );

    tex_cache_way_ram #(.NUM_PORTS(NUM_PORTS), .INDEX_BITS(INDEX_BITS)) u_way1 (
        .i_clk(i_clk), .i_we(wrEn && wrWay), .i_wrAddr(wrSet), .i_wrData(wrEntry),
        .o_wrProbe(probe1), .i_rdAddr(lkSet), .o_rdData(rd1)
    );

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [ADDR_BITS-1:0] swz;
        logic                 match0, match1;
        logic [63:0]          line;

        assign swz = swizzle(i_adressLook[p*LOOK_BITS+2 +: ADDR_BITS], i_textureFormatTrueColor);
        assign lkSet[p*INDEX_BITS +: INDEX_BITS] = swz[INDEX_BITS-1:0];
        assign lkTag[p] = swz >> INDEX_BITS;

        // Valid flops already reflect last cycle's write/clear, matching the bypassed RAM data.
        assign match0     = valid0[setR[p]] && rd0[p].tag == tagR[p];
        assign match1     = valid1[setR[p]] && rd1[p].tag == tagR[p];
        assign hitWay0[p] = match0;
        assign o_isHit[p] = reqR[p] && (match0 || match1);
        assign line       = match0 ? rd0[p].data : rd1[p].data;
        assign o_dataOut[p*16 +: 16] = line[selR[p]*16 +: 16];
        assign o_isMiss[p] = (reqR[p] || sticky[p]) && !o_isHit[p];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
            reqR   <= '0;
            sticky <= '0;
        end else begin
            reqR   <= i_requLookup;
            sticky <= i_clearCache ? '0 : o_isMiss;
            // Descending order so the lowest hitting port's update lands last.
            for (int p = NUM_PORTS-1; p >= 0; p--)
                if (o_isHit[p]) lru[setR[p]] <= hitWay0[p];
            if (i_clearCache) begin
                valid0 <= '0;
                valid1 <= '0;
                lru    <= '0;
            end else if (i_write) begin
                if (wrWay) valid1[wrSet] <= 1'b1;
                else       valid0[wrSet] <= 1'b1;
                lru[wrSet] <= !wrWay;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            setR[p] <= lkSet[p*INDEX_BITS +: INDEX_BITS];
            tagR[p] <= lkTag[p];
            selR[p] <= i_adressLook[p*LOOK_BITS +: 2];
        end
    end

endmodule
